food_placer: RTL and testbench
==============================

// Module: food_placer
// PURPOSE
//  Consumer of the free-running random grid-point stream (randX/randY, 20px grid, 800x600 field).
//  On an eat event, samples candidates and rejects those out of range or on the snake body.
//  Body test uses an occupancy query handshake to the snake body store; drives registered food position.
//  Sits between random-point generator, collision logic (eat) and VGA renderer (food_x/food_y).
// PARAMETERS
//  GRID       20   cell pitch in pixels
//  X_MIN      20   lowest legal food x;  X_MAX 760 highest legal food x
//  Y_MIN      20   lowest legal food y;  Y_MAX 560 highest legal food y
//  INIT_X     400  food x after reset / fallback;  INIT_Y 300 food y after reset / fallback
//  MAX_TRIES  16   rejected candidates allowed before fallback (try counter width = clog2(MAX_TRIES)+1)
// PORTS
//  CLK_100MHz   in   1   sole clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  rand_x       in   11  candidate x from random-point generator (changes every clock)
//  rand_y       in   11  candidate y from random-point generator
//  eat          in   1   1-cycle pulse: snake head hit food
//  query_valid  out  1   occupancy query request, held until answered
//  query_x      out  11  candidate x under query;  query_y out 11 candidate y under query
//  occ_valid    in   1   responder answer strobe, meaningful only while query_valid=1
//  occupied     in   1   1 = candidate cell lies on snake body (qualified by occ_valid)
//  food_x       out  11  current food x;  food_y out 11 current food y
//  food_valid   out  1   1 = food_x/food_y displayable
//  busy         out  1   1 = search in progress (state != IDLE)
//  placed       out  1   1-cycle pulse: new food position committed
//  fail         out  1   1-cycle pulse: MAX_TRIES exhausted, fallback position committed
// BEHAVIOUR
//  Reset (async, any state): food_x=INIT_X, food_y=INIT_Y, food_valid=1, busy=0, placed=0, fail=0,
//   query_valid=0, query_x=query_y=0, try_cnt=0, state=IDLE. Abandons any query in flight.
//  States: IDLE, SAMPLE, QUERY. All outputs registered.
//  IDLE: eat=1 -> SAMPLE; food_valid<=0, try_cnt<=0. eat ignored in SAMPLE/QUERY.
//  SAMPLE: latch cand=(rand_x,rand_y). Legal iff X_MIN<=x<=X_MAX and Y_MIN<=y<=Y_MAX, no X/Z assumed.
//   legal -> QUERY, query_valid<=1, query_x/y<=cand. illegal -> reject (see below), stay SAMPLE.
//  QUERY: query_valid/query_x/query_y stable until occ_valid=1 (same-cycle or later answer allowed).
//   occ_valid & !occupied -> accept: food<=cand, food_valid<=1, placed<=1, query_valid<=0, -> IDLE.
//   occ_valid & occupied  -> reject, query_valid<=0, -> SAMPLE. No response timeout.
//  Reject: if try_cnt==MAX_TRIES-1 -> food<=(INIT_X,INIT_Y), food_valid<=1, fail<=1, -> IDLE
//   (no occupancy check on fallback); else try_cnt<=try_cnt+1.
//  Latency eat->placed: min 3 cycles (eat@0, SAMPLE@1, QUERY@2 with same-cycle answer, placed@3).
//  food_x/food_y unchanged from eat until commit; only food_valid drops.
//  Coordinates unsigned 11-bit; comparisons unsigned; no arithmetic on candidates.
// CONFIGURATION
//  FOOD_BORDER_EN defined: legality also excludes outer ring (x==X_MIN, x==X_MAX, y==Y_MIN, y==Y_MAX);
//   such candidates rejected in SAMPLE without query, counted as tries.
//  FOOD_BORDER_EN undefined: full X_MIN..X_MAX x Y_MIN..Y_MAX range legal.
// STRUCTURE
//  Shared package snake_pkg: COORD_W=11, GRID, field bounds, INIT_X/INIT_Y defaults, state encoding.
//  Sub-module food_cand_check: combinational legality test (range + optional border), output legal.
//  Top: FSM, try counter, candidate/food registers, query handshake.
// TESTING
//  Reset release -> food=(400,300), food_valid=1, busy=0, query_valid=0, placed=0.
//  eat, rand=(100,200), occ_valid=1 occupied=0 same cycle -> placed@3, food=(100,200), food_valid=1.
//  eat, 1st query occupied=1, 2nd rand=(120,220) free, answer delayed 2 cycles -> query held, food=(120,220).
//  eat, rand_x=780 then (40,40) -> 780 rejected with no query_valid; (40,40) queried and placed.
//  occupied=1 on every query, MAX_TRIES=16 -> fail pulse after 16th reject, food=(400,300); reset mid-QUERY -> query_valid 0 at once.
//  rand=(20,100) free -> rejected with FOOD_BORDER_EN, placed at (20,100) without it.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game constants: coordinate width, grid pitch, food field bounds,
// reset/fallback food position and the food placer state encoding.
package snake_pkg;

    localparam int unsigned COORD_W       = 11;
    localparam int unsigned GRID          = 20;
    localparam int unsigned X_MIN_DEF     = 20;
    localparam int unsigned X_MAX_DEF     = 760;
    localparam int unsigned Y_MIN_DEF     = 20;
    localparam int unsigned Y_MAX_DEF     = 560;
    localparam int unsigned INIT_X_DEF    = 400;
    localparam int unsigned INIT_Y_DEF    = 300;
    localparam int unsigned MAX_TRIES_DEF = 16;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_QUERY  = 2'd2
    } fp_state_t;

    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/food_cand_check.sv
// Combinational legality test for a food candidate: inside the field bounds and,
// with FOOD_BORDER_EN defined, also off the outermost ring of the field.
module food_cand_check
    import snake_pkg::*;
#(
    parameter int unsigned X_MIN = X_MIN_DEF,
    parameter int unsigned X_MAX = X_MAX_DEF,
    parameter int unsigned Y_MIN = Y_MIN_DEF,
    parameter int unsigned Y_MAX = Y_MAX_DEF
) (
    input  logic [COORD_W-1:0] cand_x_i,
    input  logic [COORD_W-1:0] cand_y_i,
    output logic               legal_o
);

    localparam coord_t XLO = coord_t'(X_MIN);
    localparam coord_t XHI = coord_t'(X_MAX);
    localparam coord_t YLO = coord_t'(Y_MIN);
    localparam coord_t YHI = coord_t'(Y_MAX);

    logic in_range;
    logic on_border;

    always_comb begin
        in_range  = in_span(cand_x_i, XLO, XHI) && in_span(cand_y_i, YLO, YHI);
        on_border = (cand_x_i == XLO) || (cand_x_i == XHI) ||
                    (cand_y_i == YLO) || (cand_y_i == YHI);
`ifdef FOOD_BORDER_EN
        legal_o = in_range && !on_border;
`else
        legal_o = in_range;
`endif
    end

    // Border detect is only consumed when the ring exclusion is built in.
    logic unused_border;
    assign unused_border = on_border;

endmodule

// File: rtl/food_placer.sv
// Food placer: on eat, samples random grid candidates, rejects out-of-range or
// occupied cells via an occupancy query, falls back to INIT position after MAX_TRIES.
// Optional build macro: FOOD_BORDER_EN (excludes the outer ring of the field).
module food_placer
    import snake_pkg::*;
#(
    parameter int unsigned X_MIN     = X_MIN_DEF,
    parameter int unsigned X_MAX     = X_MAX_DEF,
    parameter int unsigned Y_MIN     = Y_MIN_DEF,
    parameter int unsigned Y_MAX     = Y_MAX_DEF,
    parameter int unsigned INIT_X    = INIT_X_DEF,
    parameter int unsigned INIT_Y    = INIT_Y_DEF,
    parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic               CLK_100MHz,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] rand_x,
    input  logic [COORD_W-1:0] rand_y,
    input  logic               eat,
    output logic               query_valid,
    output logic [COORD_W-1:0] query_x,
    output logic [COORD_W-1:0] query_y,
    input  logic               occ_valid,
    input  logic               occupied,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid,
    output logic               busy,
    output logic               placed,
    output logic               fail
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam coord_t FALLBACK_X = coord_t'(INIT_X);
    localparam coord_t FALLBACK_Y = coord_t'(INIT_Y);

    fp_state_t        state_q, state_d;
    logic [TRY_W-1:0] try_q, try_d;
    logic             qv_q, qv_d;
    coord_t           qx_q, qx_d;
    coord_t           qy_q, qy_d;
    coord_t           fx_q, fx_d;
    coord_t           fy_q, fy_d;
    logic             fv_q, fv_d;
    logic             busy_q, busy_d;
    logic             placed_q, placed_d;
    logic             fail_q, fail_d;

    logic cand_legal;
    logic reject;

    food_cand_check #(
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
    ) u_cand_check (
        .cand_x_i (rand_x),
        .cand_y_i (rand_y),
        .legal_o  (cand_legal)
    );

    always_comb begin
        state_d  = state_q;
        try_d    = try_q;
        qv_d     = qv_q;
        qx_d     = qx_q;
        qy_d     = qy_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        fv_d     = fv_q;
        placed_d = 1'b0;
        fail_d   = 1'b0;
        reject   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (eat) begin
                    state_d = ST_SAMPLE;
                    fv_d    = 1'b0;
                    try_d   = '0;
                end
            end
            ST_SAMPLE: begin
                if (cand_legal) begin
                    state_d = ST_QUERY;
                    qv_d    = 1'b1;
                    qx_d    = rand_x;
                    qy_d    = rand_y;
                end else begin
                    reject = 1'b1;
                end
            end
            ST_QUERY: begin
                if (occ_valid) begin
                    qv_d = 1'b0;
                    if (!occupied) begin
                        state_d  = ST_IDLE;
                        fx_d     = qx_q;
                        fy_d     = qy_q;
                        fv_d     = 1'b1;
                        placed_d = 1'b1;
                    end else begin
                        state_d = ST_SAMPLE;
                        reject  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                qv_d    = 1'b0;
                fv_d    = 1'b1;
            end
        endcase

        // Both rejection sources share one try budget; the last one forces the fallback.
        if (reject) begin
            if (try_q == TRY_LAST) begin
                state_d = ST_IDLE;
                fx_d    = FALLBACK_X;
                fy_d    = FALLBACK_Y;
                fv_d    = 1'b1;
                fail_d  = 1'b1;
            end else begin
                try_d = try_q + TRY_W'(1);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            try_q    <= '0;
            qv_q     <= 1'b0;
            qx_q     <= '0;
            qy_q     <= '0;
            fx_q     <= FALLBACK_X;
            fy_q     <= FALLBACK_Y;
            fv_q     <= 1'b1;
            busy_q   <= 1'b0;
            placed_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            try_q    <= try_d;
            qv_q     <= qv_d;
            qx_q     <= qx_d;
            qy_q     <= qy_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            fv_q     <= fv_d;
            busy_q   <= busy_d;
            placed_q <= placed_d;
            fail_q   <= fail_d;
        end
    end

    assign query_valid = qv_q;
    assign query_x     = qx_q;
    assign query_y     = qy_q;
    assign food_x      = fx_q;
    assign food_y      = fy_q;
    assign food_valid  = fv_q;
    assign busy        = busy_q;
    assign placed      = placed_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_food_placer.sv
// Self-checking bench for food_placer: directed scenarios plus random episodes
// checked cycle by cycle against a schedule derived from the placement rules.
module tb_food_placer;

    localparam int XMN = 20, XMX = 760, YMN = 20, YMX = 560;
    localparam int IX = 400, IY = 300, TRIES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] rand_x, rand_y;
    logic        eat, occ_valid, occupied;
    logic        query_valid, food_valid, busy, placed, fail;
    logic [10:0] query_x, query_y, food_x, food_y;

    always #5 clk = ~clk;

    food_placer dut (
        .CLK_100MHz  (clk),
        .rst_n       (rst_n),
        .rand_x      (rand_x),
        .rand_y      (rand_y),
        .eat         (eat),
        .query_valid (query_valid),
        .query_x     (query_x),
        .query_y     (query_y),
        .occ_valid   (occ_valid),
        .occupied    (occupied),
        .food_x      (food_x),
        .food_y      (food_y),
        .food_valid  (food_valid),
        .busy        (busy),
        .placed      (placed),
        .fail        (fail)
    );

    int ncmp = 0;
    int nerr = 0;

    // Episode stimulus: candidate stream per cycle, per-query answer delay and occupancy.
    int sx[0:127], sy[0:127];
    int qdly[0:31];
    bit qocc[0:31];
    bit eat_noise;

    // Expected schedule.
    bit eqv[0:127];
    int eqx[0:127], eqy[0:127];
    bit ans_v[0:127], ans_o[0:127];
    int end_c;
    bit exp_fail;
    int nfx, nfy;
    int cur_fx, cur_fy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int x, input int y);
        bit ok;
        ok = (x >= XMN) && (x <= XMX) && (y >= YMN) && (y <= YMX);
`ifdef FOOD_BORDER_EN
        ok = ok && (x != XMN) && (x != XMX) && (y != YMN) && (y != YMX);
`endif
        return ok;
    endfunction

    task automatic fill(input int x, input int y);
        for (int i = 0; i < 128; i++) begin sx[i] = x; sy[i] = y; end
        for (int i = 0; i < 32; i++) begin qdly[i] = 0; qocc[i] = 1'b0; end
    endtask

    // Walk the candidate stream as the placement rules dictate: each sampling
    // cycle consumes one candidate; a legal one is queried until answered.
    task automatic build_schedule();
        int s, tries, k, a;
        for (int i = 0; i < 128; i++) begin
            eqv[i] = 0; eqx[i] = 0; eqy[i] = 0; ans_v[i] = 0; ans_o[i] = 0;
        end
        s = 1; tries = 0; k = 0; exp_fail = 0; end_c = 0;
        while (end_c == 0) begin
            if (!legal(sx[s], sy[s])) begin
                tries++;
                if (tries == TRIES) begin exp_fail = 1; end_c = s + 1; end
                else s = s + 1;
            end else begin
                a = s + 1 + qdly[k];
                for (int c = s + 1; c <= a; c++) begin
                    eqv[c] = 1; eqx[c] = sx[s]; eqy[c] = sy[s];
                end
                ans_v[a] = 1; ans_o[a] = qocc[k];
                if (!qocc[k]) begin
                    nfx = sx[s]; nfy = sy[s]; end_c = a + 1;
                end else begin
                    tries++;
                    if (tries == TRIES) begin exp_fail = 1; end_c = a + 1; end
                    else s = a + 1;
                end
                k++;
            end
        end
        if (exp_fail) begin nfx = IX; nfy = IY; end
    endtask

    task automatic run_episode(input string name);
        build_schedule();
        @(posedge clk); #1;
        eat = 1'b1; rand_x = 11'(sx[0]); rand_y = 11'(sy[0]); occ_valid = 1'b0; occupied = 1'b0;
        @(negedge clk);
        chk({name, ".c0_busy"}, busy, 0);
        chk({name, ".c0_fv"}, food_valid, 1);
        chk({name, ".c0_qv"}, query_valid, 0);
        for (int c = 1; c <= end_c + 1; c++) begin
            @(posedge clk); #1;
            eat       = (c < end_c && eat_noise) ? 1'($urandom_range(0, 1)) : 1'b0;
            rand_x    = 11'(sx[c]);
            rand_y    = 11'(sy[c]);
            occ_valid = ans_v[c];
            occupied  = ans_v[c] ? ans_o[c] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c < end_c) begin
                chk({name, ".qv"}, query_valid, eqv[c]);
                if (eqv[c]) begin
                    chk({name, ".qx"}, query_x, eqx[c]);
                    chk({name, ".qy"}, query_y, eqy[c]);
                end
                chk({name, ".busy"}, busy, 1);
                chk({name, ".fv"}, food_valid, 0);
                chk({name, ".placed"}, placed, 0);
                chk({name, ".fail"}, fail, 0);
                chk({name, ".hold_fx"}, food_x, cur_fx);
                chk({name, ".hold_fy"}, food_y, cur_fy);
            end else begin
                chk({name, ".end_qv"}, query_valid, 0);
                chk({name, ".end_busy"}, busy, 0);
                chk({name, ".end_fv"}, food_valid, 1);
                chk({name, ".end_placed"}, placed, (c == end_c) ? !exp_fail : 1'b0);
                chk({name, ".end_fail"}, fail, (c == end_c) ? exp_fail : 1'b0);
                chk({name, ".end_fx"}, food_x, nfx);
                chk({name, ".end_fy"}, food_y, nfy);
            end
        end
        chk({name, ".latency"}, end_c, end_c);
        ncmp--;  // the latency line above only records; keep counts honest
        cur_fx = nfx; cur_fy = nfy;
    endtask

    initial begin
        int p, r;
        rst_n = 1'b0; eat = 1'b0; rand_x = '0; rand_y = '0; occ_valid = 1'b0; occupied = 1'b0;
        eat_noise = 1'b0;
        cur_fx = IX; cur_fy = IY;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst.fx", food_x, IX);
        chk("rst.fy", food_y, IY);
        chk("rst.fv", food_valid, 1);
        chk("rst.busy", busy, 0);
        chk("rst.qv", query_valid, 0);
        chk("rst.placed", placed, 0);
        chk("rst.fail", fail, 0);

        // Same-cycle free answer: placed three cycles after eat.
        fill(100, 200);
        run_episode("basic");
        chk("basic.end_cycle", end_c, 3);

        // First query occupied, second candidate answered two cycles late.
        fill(120, 220);
        sx[1] = 60; sy[1] = 60; qocc[0] = 1; qdly[1] = 2;
        run_episode("delayed");

        // Out-of-range x rejected without a query.
        fill(40, 40);
        sx[1] = 780;
        run_episode("range");

        // Reset while a query is outstanding.
        @(posedge clk); #1;
        eat = 1'b1; rand_x = 11'd100; rand_y = 11'd100; occ_valid = 1'b0;
        @(posedge clk); #1 eat = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midq.qv_before", query_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midq.qv", query_valid, 0);
        chk("midq.qx", query_x, 0);
        chk("midq.busy", busy, 0);
        chk("midq.fv", food_valid, 1);
        chk("midq.fx", food_x, IX);
        chk("midq.fy", food_y, IY);
        @(posedge clk); #1 rst_n = 1'b1;
        cur_fx = IX; cur_fy = IY;

        // Move food away from the fallback so the fallback commit is visible.
        fill(200, 200);
        run_episode("pre_fb");

        // Every query occupied: fallback after the sixteenth rejection.
        fill(100, 100);
        for (int i = 0; i < 32; i++) qocc[i] = 1;
        run_episode("fallback");

        // Candidate on the left edge of the field.
        fill(20, 100);
        run_episode("edge");

        // Random episodes with eat noise while busy.
        eat_noise = 1'b1;
        for (int e = 0; e < 40; e++) begin
            p = $urandom_range(0, 100);
            for (int c = 0; c < 128; c++) begin
                r = $urandom_range(0, 99);
                if (r < 55) begin
                    sx[c] = 20 * $urandom_range(1, 38); sy[c] = 20 * $urandom_range(1, 28);
                end else if (r < 70) begin
                    sx[c] = ($urandom_range(0, 1) != 0) ? XMN : XMX;
                    sy[c] = ($urandom_range(0, 1) != 0) ? YMN : 20 * $urandom_range(1, 28);
                end else begin
                    sx[c] = $urandom_range(0, 2047); sy[c] = $urandom_range(0, 2047);
                end
            end
            for (int k = 0; k < 32; k++) begin
                qdly[k] = $urandom_range(0, 2);
                qocc[k] = ($urandom_range(0, 99) < p);
            end
            run_episode("rand");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1 eat = 1'b0;
                @(negedge clk);
                chk("gap.busy", busy, 0);
                chk("gap.fx", food_x, cur_fx);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
